// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel receive path.
package sipo_pkg;

    // Receiver FSM states: waiting for a start-of-frame, or assembling a word.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    // Width of a bit counter that must reach width-1.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial input and word output bundle of the deframer.
interface sipo_deframer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sof;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    // Upstream source plus downstream consumer side.
    modport master (
        output sin, sin_valid, sof, out_ready,
        input  data_out, out_valid, busy, frame_err, overrun
    );

    // The deframer itself.
    modport slave (
        input  sin, sin_valid, sof, out_ready,
        output data_out, out_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/out_reg_1.sv
// One-entry valid/ready holding register. A load while the slot is still
// occupied and not being drained is dropped and recorded in a sticky flag.
module out_reg_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);
    logic [WIDTH-1:0] data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    // Next-state: drain on handshake, then accept or drop a new word.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (!valid_q || ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Register the slot contents and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset as well because it is directly
            // visible on data_out and must read as zero out of reset.
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel receive stage: regroups a qualified serial bit stream
// into WIDTH-bit words aligned by a start-of-frame marker.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    sipo_deframer_if.slave s
);
    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic             busy_q,      busy_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             word_done;

    // Shift-register images: next bit appended, or a fresh frame's bit 0.
    always_comb begin
        if (MSB_FIRST) begin
            shifted    = {shreg_q[WIDTH-2:0], s.sin};
            first_word = {{(WIDTH-1){1'b0}}, s.sin};
        end else begin
            shifted    = {s.sin, shreg_q[WIDTH-1:1]};
            first_word = {s.sin, {(WIDTH-1){1'b0}}};
        end
    end

    // Frame FSM next-state: bit counting, resync on sof, stray-bit detection.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        if (s.sin_valid) begin
            if (s.sof) begin
                // A sof inside a frame abandons the partial word.
                frame_err_d = (state_q == ST_RECV);
                state_d     = ST_RECV;
                cnt_d       = CNT_W'(1);
                shreg_d     = first_word;
            end else if (state_q == ST_IDLE) begin
                frame_err_d = 1'b1;
            end else begin
                shreg_d = shifted;
                if (cnt_q == LAST_CNT) begin
                    word_done = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        busy_d = (state_d == ST_RECV);
    end

    // FSM state, counter, shift register and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    out_reg_1 #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (word_done),
        .load_data(shifted),
        .ready    (s.out_ready),
        .data     (s.data_out),
        .valid    (s.out_valid),
        .overrun  (s.overrun)
    );

    assign s.busy      = busy_q;
    assign s.frame_err = frame_err_q;
endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench: two deframers (MSB-first and LSB-first) share one
// stimulus stream and are compared with a frame-level reference model.
module tb_sipo_deframer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_deframer_if #(.WIDTH(W)) bus_m ();
    sipo_deframer_if #(.WIDTH(W)) bus_l ();

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .s(bus_m));
    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .s(bus_l));

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is the list of bits received since sof.
    bit         m_in_frame;
    bit         m_bits[$];
    logic [W-1:0] m_data_m, m_data_l;
    bit         m_valid, m_over, m_err;

    function automatic logic [W-1:0] pack_word(input bit msb_first);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = m_bits[i];
            else           w[i]     = m_bits[i];
        end
        return w;
    endfunction

    function automatic void model_reset();
        m_in_frame = 0;
        m_bits.delete();
        m_data_m = '0;
        m_data_l = '0;
        m_valid  = 0;
        m_over   = 0;
        m_err    = 0;
    endfunction

    task automatic set_inputs(input bit sin, input bit sv, input bit sof, input bit rdy);
        bus_m.sin = sin; bus_m.sin_valid = sv; bus_m.sof = sof; bus_m.out_ready = rdy;
        bus_l.sin = sin; bus_l.sin_valid = sv; bus_l.sof = sof; bus_l.out_ready = rdy;
    endtask

    // One clock: drive at negedge, advance model, settle 1 unit after posedge.
    task automatic step(input bit sin, input bit sv, input bit sof, input bit rdy);
        bit done = 0;
        bit xfer;
        @(negedge clk);
        set_inputs(sin, sv, sof, rdy);
        xfer  = m_valid && rdy;
        m_err = 0;
        if (sv) begin
            if (sof) begin
                m_err = m_in_frame;
                m_bits.delete();
                m_bits.push_back(sin);
                m_in_frame = 1;
            end else if (!m_in_frame) begin
                m_err = 1;
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == W) done = 1;
            end
        end
        if (xfer) m_valid = 0;
        if (done) begin
            if (!m_valid) begin
                m_data_m = pack_word(1'b1);
                m_data_l = pack_word(1'b0);
                m_valid  = 1;
            end else begin
                m_over = 1;
            end
            m_in_frame = 0;
            m_bits.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed mid-way through the low clock phase.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        set_inputs(0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        if (bus_m.busy !== 1'b0 || bus_m.out_valid !== 1'b0 || bus_m.data_out !== 4'h0 ||
            bus_m.frame_err !== 1'b0 || bus_m.overrun !== 1'b0 || bus_l.data_out !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b data_m=%h data_l=%h err=%b ovr=%b, want all 0",
                     bus_m.busy, bus_m.out_valid, bus_m.data_out, bus_l.data_out,
                     bus_m.frame_err, bus_m.overrun);
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_inputs(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (bus_m.data_out !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus_m.data_out); end
        checks++;
        if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_m.out_valid); end
        checks++;
        if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_m.busy); end
        checks++;
        if (bus_m.frame_err !== 1'b0 || bus_m.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: err=%b ovr=%b want 0 0", bus_m.frame_err, bus_m.overrun);
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit b[4] = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step(b[i], 1, i == 0, 1);
            if (bus_m.frame_err !== 1'b0 || bus_m.overrun !== 1'b0) begin
                errors++;
                $display("FAIL basic_flags[%0d]: err=%b ovr=%b want 0 0", i, bus_m.frame_err, bus_m.overrun);
            end
            checks++;
            if (i < 3 && bus_m.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid[%0d]: got %b want 0", i, bus_m.out_valid);
            end
            if (i < 3) checks++;
        end
        if (bus_m.out_valid !== 1'b1 || bus_m.data_out !== 4'hB) begin
            errors++;
            $display("FAIL basic_msb: valid=%b data=%h want 1 b", bus_m.out_valid, bus_m.data_out);
        end
        checks++;
        if (bus_l.out_valid !== 1'b1 || bus_l.data_out !== 4'hD) begin
            errors++;
            $display("FAIL basic_lsb: valid=%b data=%h want 1 d", bus_l.out_valid, bus_l.data_out);
        end
        checks++;
        step(0, 0, 0, 1);
        if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: valid=%b want 0", bus_m.out_valid); end
        checks++;
    endtask

    task automatic test_gap();
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            if (bus_m.busy !== 1'b1 || bus_m.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_busy[%0d]: busy=%b valid=%b want 1 0", i, bus_m.busy, bus_m.out_valid);
            end
            checks++;
        end
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        if (bus_m.data_out !== 4'hC || bus_m.out_valid !== 1'b1 || bus_m.busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_word: data=%h valid=%b busy=%b want c 1 0",
                     bus_m.data_out, bus_m.out_valid, bus_m.busy);
        end
        checks++;
        step(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back_overrun();
        bit b[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) step(b[i], 1, (i % 4) == 0, 0);
        if (bus_m.data_out !== 4'hA || bus_m.overrun !== 1'b1 || bus_m.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold: data=%h ovr=%b valid=%b want a 1 1",
                     bus_m.data_out, bus_m.overrun, bus_m.out_valid);
        end
        checks++;
        step(0, 0, 0, 1);
        if (bus_m.out_valid !== 1'b0 || bus_m.overrun !== 1'b1 || bus_m.data_out !== 4'hA) begin
            errors++;
            $display("FAIL overrun_drain: valid=%b ovr=%b data=%h want 0 1 a",
                     bus_m.out_valid, bus_m.overrun, bus_m.data_out);
        end
        checks++;
        step(0, 0, 0, 1);
        if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_single: valid=%b want 0", bus_m.out_valid); end
        checks++;
    endtask

    task automatic test_resync();
        bit b[6] = '{1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            step(b[i], 1, i == 0 || i == 2, 1);
            if (bus_m.frame_err !== (i == 2)) begin
                errors++;
                $display("FAIL resync_err[%0d]: got %b want %b", i, bus_m.frame_err, i == 2);
            end
            checks++;
        end
        if (bus_m.data_out !== 4'h6 || bus_m.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resync_word: data=%h valid=%b want 6 1", bus_m.data_out, bus_m.out_valid);
        end
        checks++;
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset_midframe();
        bit b[4] = '{1, 0, 0, 1};
        step(1, 1, 1, 1);
        step(0, 1, 0, 1);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(b[i], 1, 0, 1);
            if (bus_m.frame_err !== 1'b1 || bus_m.out_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
                errors++;
                $display("FAIL stray_bit[%0d]: err=%b valid=%b busy=%b want 1 0 0",
                         i, bus_m.frame_err, bus_m.out_valid, bus_m.busy);
            end
            checks++;
        end
        step(0, 0, 0, 1);
        if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL stray_pulse_end: err=%b want 0", bus_m.frame_err); end
        checks++;
        for (int i = 0; i < 4; i++) step(b[i], 1, i == 0, 1);
        if (bus_m.data_out !== 4'h9 || bus_m.out_valid !== 1'b1 || bus_m.overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: data=%h valid=%b ovr=%b want 9 1 0",
                     bus_m.data_out, bus_m.out_valid, bus_m.overrun);
        end
        checks++;
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
            if (bus_m.data_out !== m_data_m || bus_l.data_out !== m_data_l ||
                bus_m.out_valid !== m_valid || bus_l.out_valid !== m_valid ||
                bus_m.busy !== m_in_frame || bus_m.frame_err !== m_err ||
                bus_m.overrun !== m_over || bus_l.overrun !== m_over) begin
                errors++;
                $display("FAIL random[%0d]: got dm=%h dl=%h v=%b busy=%b err=%b ovr=%b want dm=%h dl=%h v=%b busy=%b err=%b ovr=%b",
                         n, bus_m.data_out, bus_l.data_out, bus_m.out_valid, bus_m.busy,
                         bus_m.frame_err, bus_m.overrun, m_data_m, m_data_l, m_valid,
                         m_in_frame, m_err, m_over);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_back_to_back_overrun();
        test_resync();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-to-parallel receive stage that sits directly downstream of the 4-bit PISO shifter.
- Consumes the MSB-first serial bit stream and regroups it into WIDTH-bit words, using a start-of-frame qualifier for alignment.
- Presents each completed word through a one-entry valid/ready output register.
- Flags framing errors and output overruns so the consumer can detect lost data.

Parameters:
- WIDTH, 4, word length in bits; must be ≥ 2; matches the upstream PISO width.
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock, shared with upstream PISO
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- sin  input  1  serial data bit
- sin_valid  input  1  sin carries a valid bit this cycle
- sof  input  1  start-of-frame; qualified only when sin_valid=1; marks bit 0 of a word
- data_out  output  WIDTH  assembled word; stable while out_valid=1
- out_valid  output  1  data_out holds an unconsumed word
- out_ready  input  1  consumer accepts the word when out_valid & out_ready
- busy  output  1  frame in progress (state RECV)
- frame_err  output  1  one-cycle pulse on a framing violation
- overrun  output  1  sticky; set when a completed word is dropped; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit count=0, data_out=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- A bit is consumed only on a clk edge with sin_valid=1. With sin_valid=0, all state holds and gaps of any length are allowed.
- FSM states: IDLE, RECV.
- IDLE:
  - sin_valid & sof: capture sin as bit 0, count=1, go to RECV.
  - sin_valid & !sof: discard the bit and pulse frame_err (stray bit outside a frame).
- RECV:
  - sin_valid & !sof: shift sin in, count+1.
  - When the bit with count=WIDTH-1 is consumed, the word is complete: return to IDLE, count=0.
- sof inside RECV:
  - Discard the partial word and pulse frame_err.
  - Treat the current bit as bit 0 of a new frame: count=1, stay in RECV.
- Shift direction:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
- Word completion, decided on the same edge that consumes the last bit:
  - out_valid=0, or out_valid & out_ready: load data_out with the completed word and set out_valid=1.
  - out_valid=1 & out_ready=0: drop the new word, set overrun=1, keep the old data_out unchanged.
- Latency: out_valid rises on the clk edge that samples the last bit, i.e. visible in the cycle after that bit is presented.
- Handshake:
  - Transfer occurs on any edge with out_valid & out_ready.
  - out_valid clears after the transfer unless a new word completes on that same edge; in that case out_valid stays 1 with the new data.
  - out_ready is ignored while out_valid=0.
- busy = (state==RECV), registered.
- frame_err is a registered pulse, high for exactly one cycle per violation.
- Back-to-back frames: a sof on the cycle immediately after completion is legal and needs no idle gap.
- Reset mid-frame: the partial word is lost and no frame_err is raised. After reset release, the block waits for sof.

Decomposition:
- Shared package (sipo_pkg):
  - State encoding constants: ST_IDLE=1'b0, ST_RECV=1'b1.
  - Count-width function: CNT_W = $clog2(WIDTH).
- Sub-module out_reg_1: one-entry valid/ready holding register with load, drop and overrun logic. It is reusable by other receive stages.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset, then sof=1 with bits 1,0,1,1 on four consecutive sin_valid cycles, out_ready=1 → data_out=4'hB and out_valid=1 after the 4th edge, frame_err=0 and overrun=0 throughout.
- MSB_FIRST=0, same bits 1,0,1,1 → data_out=4'hD.
- Bits 1,1,0,0 with sin_valid low for 3 cycles between bits 2 and 3 → data_out=4'hC; busy stays high throughout the gap.
- Two frames 4'hA then 4'h5 back-to-back with out_ready=0 → data_out stays 4'hA, overrun=1. Then out_ready=1 → one transfer of 4'hA, out_valid=0, overrun remains 1.
- sof, 2 bits (1,1), then sof with bits 0,1,1,0 → frame_err pulses for 1 cycle on the 2nd sof, data_out=4'h6.
- Assert rst=0 asynchronously after 2 of 4 bits → all outputs 0 immediately. Release, then send bits 1,0,0,1 without sof → frame_err pulses 4 times, no word produced. Then a full frame 4'h9 with sof → data_out=4'h9.
